pipe_stage_chain: RTL

- Parametrised, multi-stage successor to the fixed ID/EX pipeline register.
- Carries a valid bit plus a DATA_W data payload and a CTRL_W control payload through DEPTH register stages.
- Supports per-stage stall (hold) with upstream propagation, automatic bubble insertion below a stall point, and per-stage flush.
- Provides saturating stall/kill performance counters for the hazard unit and debug.

---
 rtl/pipe_stage_chain_if.sv | 29 ++
 rtl/pipe_stage_chain.sv | 109 ++++++++++
 2 files changed

// File: rtl/pipe_stage_chain_if.sv
// Pipeline bus for pipe_stage_chain: stage-0 input handshake, per-stage
// stall/flush controls and the per-stage valid/data/ctrl taps.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2
);
  logic                     i_valid;
  logic [DATA_W-1:0]        i_data;
  logic [CTRL_W-1:0]        i_ctrl;
  logic                     o_ready;
  logic [DEPTH-1:0]         i_stall;
  logic [DEPTH-1:0]         i_flush;
  logic [DEPTH-1:0]         o_valid;
  logic [DEPTH*DATA_W-1:0]  o_data;
  logic [DEPTH*CTRL_W-1:0]  o_ctrl;

  // Producer / hazard-unit side
  modport master (
    output i_valid, i_data, i_ctrl, i_stall, i_flush,
    input  o_ready, o_valid, o_data, o_ctrl
  );

  // Pipeline side
  modport slave (
    input  i_valid, i_data, i_ctrl, i_stall, i_flush,
    output o_ready, o_valid, o_data, o_ctrl
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of DEPTH pipeline registers carrying valid + data + ctrl.
// A stall at stage k freezes stages 0..k and drops a bubble into stage k+1;
// a flush zeroes its stage and overrides any hold. Two saturating counters
// track stalled cycles and valid items killed by flush.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr_cnt,
  pipe_stage_chain_if.slave    bus,
  output logic [CNT_W-1:0]     o_stall_cnt,
  output logic [CNT_W-1:0]     o_kill_cnt
);

  logic [DEPTH-1:0]              hold;
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][DATA_W-1:0]  data_q, data_d;
  logic [DEPTH-1:0][CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]              kill_cnt_q, kill_cnt_d;
  logic [CNT_W-1:0]              kill_inc;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Hold chain: a stall propagates towards stage 0.
  always_comb begin
    hold = '0;
    hold[DEPTH-1] = bus.i_stall[DEPTH-1];
    for (int k = DEPTH - 2; k >= 0; k--) begin
      hold[k] = bus.i_stall[k] | hold[k+1];
    end
  end

  // Per-stage next state: flush > hold > load (bubble when the feeder holds).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (bus.i_flush[0]) begin
      valid_d[0] = 1'b0;
      data_d[0]  = '0;
      ctrl_d[0]  = '0;
    end else if (!hold[0]) begin
      valid_d[0] = bus.i_valid;
      data_d[0]  = bus.i_valid ? bus.i_data : '0;
      ctrl_d[0]  = bus.i_valid ? bus.i_ctrl : '0;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (bus.i_flush[k] || (!hold[k] && hold[k-1])) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
        ctrl_d[k]  = '0;
      end else if (!hold[k]) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
      end
    end
  end

  // Performance counters: clear wins over a same-cycle increment.
  always_comb begin
    kill_inc = '0;
    for (int k = 0; k < DEPTH; k++) begin
      kill_inc = kill_inc + CNT_W'(bus.i_flush[k] & valid_q[k]);
    end
    stall_cnt_d = sat_add(stall_cnt_q, CNT_W'(hold[0]));
    kill_cnt_d  = sat_add(kill_cnt_q, kill_inc);
    if (i_clr_cnt) begin
      stall_cnt_d = '0;
      kill_cnt_d  = '0;
    end
  end

  // Register update; reset discards every stage and both counters at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q     <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign bus.o_ready  = ~hold[0];
  assign bus.o_valid  = valid_q;
  assign bus.o_data   = data_q;
  assign bus.o_ctrl   = ctrl_q;
  assign o_stall_cnt  = stall_cnt_q;
  assign o_kill_cnt   = kill_cnt_q;

endmodule
